// File: rtl/pa_core_csr_unit.sv
// Machine-mode CSR unit: CSR read/modify/write, trap entry, mret,
// synchronised interrupt lines with priority arbitration, 64-bit counters.
module pa_core_csr_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter logic [XLEN-1:0] HART_ID   = '0,
    parameter bit              VEC_EN    = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            csr_vld_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            instret_i,
    input  logic            trap_vld_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic            irq_ext_i,
    input  logic            irq_tmr_i,
    input  logic            irq_sw_i,
    output logic            irq_req_o,
    output logic [XLEN-1:0] irq_cause_o,
    output logic [XLEN-1:0] trap_pc_o,
    output logic [XLEN-1:0] mepc_o
);

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    // misa: MXL in the top two bits, 'I' extension bit 8
    localparam logic [1:0]      MXL  = (XLEN == 64) ? 2'b10 : 2'b01;
    localparam logic [XLEN-1:0] MISA = {MXL, (XLEN-2)'(256)};
    localparam logic [XLEN-1:0] LOW2 = XLEN'(3);

    // architectural state
    logic            mst_mie, mst_mpie;
    logic [2:0]      mie_q;                  // {meie, mtie, msie}
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [63:0]     mcycle_q, minstret_q;
    logic [1:0][2:0] irq_sync;               // [1] is the mip view, {ext, tmr, sw}

    logic [63:0]     mcycle_nxt, minstret_nxt;
    logic [XLEN-1:0] rdata, wval, mstatus_rd, mie_rd, mip_rd, vec_base;
    logic            impl, is_wr, we;
    logic [2:0]      pend;
    logic [3:0]      irq_code;

    // fixed-position views of the sparse registers
    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mst_mpie;
        mstatus_rd[3]     = mst_mie;
        mie_rd            = '0;
        mie_rd[11]        = mie_q[2];
        mie_rd[7]         = mie_q[1];
        mie_rd[3]         = mie_q[0];
        mip_rd            = '0;
        mip_rd[11]        = irq_sync[1][2];
        mip_rd[7]         = irq_sync[1][1];
        mip_rd[3]         = irq_sync[1][0];
    end

    // read mux; also flags unimplemented addresses
    always_comb begin
        rdata = '0;
        impl  = 1'b1;
        case (csr_addr_i)
            A_MSTATUS:             rdata = mstatus_rd;
            A_MISA:                rdata = MISA;
            A_MIE:                 rdata = mie_rd;
            A_MTVEC:               rdata = mtvec_q;
            A_MSCRATCH:            rdata = mscratch_q;
            A_MEPC:                rdata = mepc_q;
            A_MCAUSE:              rdata = mcause_q;
            A_MTVAL:               rdata = mtval_q;
            A_MIP:                 rdata = mip_rd;
            A_MCYCLE, A_CYCLE:     rdata = mcycle_q[XLEN-1:0];
            A_MINSTRET, A_INSTRET: rdata = minstret_q[XLEN-1:0];
            A_MCYCLEH, A_CYCLEH: begin
                if (XLEN == 32) rdata = XLEN'(mcycle_q[63:32]);
                else            impl  = 1'b0;
            end
            A_MINSTRETH, A_INSTRETH: begin
                if (XLEN == 32) rdata = XLEN'(minstret_q[63:32]);
                else            impl  = 1'b0;
            end
            A_MHARTID:             rdata = HART_ID;
            default:               impl  = 1'b0;
        endcase
    end

    assign csr_rdata_o = rdata;

    // RS/RC with a zero operand is a pure read and never counts as a write
    assign is_wr = (csr_op_i == OP_RW) |
                   (((csr_op_i == OP_RS) | (csr_op_i == OP_RC)) & (|csr_wdata_i));
    assign csr_illegal_o = csr_vld_i & (~impl | (is_wr & (csr_addr_i[11:10] == 2'b11)));
    // trap and mret both outrank a CSR write
    assign we = csr_vld_i & is_wr & ~csr_illegal_o & ~trap_vld_i & ~mret_i;

    // new value for the addressed CSR
    always_comb begin
        case (csr_op_i)
            OP_RW:   wval = csr_wdata_i;
            OP_RS:   wval = rdata | csr_wdata_i;
            OP_RC:   wval = rdata & ~csr_wdata_i;
            default: wval = rdata;
        endcase
    end

    // counters: increment, with a CSR write replacing its half in the same cycle
    always_comb begin
        mcycle_nxt   = mcycle_q + 64'd1;
        minstret_nxt = minstret_q + {63'd0, instret_i};
        if (we && csr_addr_i == A_MCYCLE)   mcycle_nxt[XLEN-1:0]   = wval;
        if (we && csr_addr_i == A_MINSTRET) minstret_nxt[XLEN-1:0] = wval;
        if (XLEN == 32 && we && csr_addr_i == A_MCYCLEH)   mcycle_nxt[63:32]   = wval[31:0];
        if (XLEN == 32 && we && csr_addr_i == A_MINSTRETH) minstret_nxt[63:32] = wval[31:0];
    end

    // interrupt arbitration: ext > sw > timer
    always_comb begin
        pend      = irq_sync[1] & mie_q;
        irq_req_o = mst_mie & (|pend);
        irq_code  = 4'd0;
        if (irq_req_o) begin
            if (pend[2])      irq_code = 4'd11;
            else if (pend[0]) irq_code = 4'd3;
            else              irq_code = 4'd7;
        end
        irq_cause_o = irq_req_o ? {1'b1, (XLEN-1)'(irq_code)} : '0;
    end

    // trap target: vectored only for interrupts when mtvec.MODE=1
    assign vec_base  = mtvec_q & ~LOW2;
    assign trap_pc_o = (mtvec_q[0] & trap_cause_i[XLEN-1])
                     ? vec_base + XLEN'({trap_cause_i[XLEN-2:0], 2'b00})
                     : vec_base;
    assign mepc_o    = mepc_q;

    // state update: trap > mret > CSR write; counters and synchronisers always run
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST & ~LOW2;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            irq_sync   <= '0;
        end else begin
            mcycle_q   <= mcycle_nxt;
            minstret_q <= minstret_nxt;
            irq_sync   <= {irq_sync[0], {irq_ext_i, irq_tmr_i, irq_sw_i}};
            if (trap_vld_i) begin
                mepc_q   <= trap_pc_i & ~LOW2;
                mcause_q <= trap_cause_i;
                mtval_q  <= trap_tval_i;
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
            end else if (mret_i) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
            end else if (we) begin
                case (csr_addr_i)
                    A_MSTATUS: begin
                        mst_mie  <= wval[3];
                        mst_mpie <= wval[7];
                    end
                    A_MIE:      mie_q      <= {wval[11], wval[7], wval[3]};
                    A_MTVEC:    mtvec_q    <= {wval[XLEN-1:2], 1'b0, wval[0] & VEC_EN};
                    A_MSCRATCH: mscratch_q <= wval;
                    A_MEPC:     mepc_q     <= wval & ~LOW2;
                    A_MCAUSE:   mcause_q   <= wval;
                    A_MTVAL:    mtval_q    <= wval;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pa_core_csr_unit.sv
// Scoreboard bench for pa_core_csr_unit (XLEN=32, MTVEC_RST=0, HART_ID=0).
module tb_pa_core_csr_unit;

    localparam logic [1:0] RD = 2'b00, RW = 2'b01, RS = 2'b10, RC = 2'b11;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        csr_vld_i;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i, csr_rdata_o;
    logic        csr_illegal_o;
    logic        instret_i, trap_vld_i, mret_i;
    logic [31:0] trap_cause_i, trap_pc_i, trap_tval_i;
    logic        irq_ext_i, irq_tmr_i, irq_sw_i;
    logic        irq_req_o;
    logic [31:0] irq_cause_o, trap_pc_o, mepc_o;

    pa_core_csr_unit #(.XLEN(32), .MTVEC_RST(32'h0), .HART_ID(32'h0), .VEC_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .csr_vld_i(csr_vld_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
        .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
        .instret_i(instret_i), .trap_vld_i(trap_vld_i), .trap_cause_i(trap_cause_i),
        .trap_pc_i(trap_pc_i), .trap_tval_i(trap_tval_i), .mret_i(mret_i),
        .irq_ext_i(irq_ext_i), .irq_tmr_i(irq_tmr_i), .irq_sw_i(irq_sw_i),
        .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o),
        .trap_pc_o(trap_pc_o), .mepc_o(mepc_o)
    );

    always #5 clk_i = ~clk_i;

    // reference cycle count: edges seen since reset release
    logic [63:0] cyc;
    always @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) cyc <= '0;
        else          cyc <= cyc + 64'd1;

    typedef struct { string tag; logic [63:0] exp; } sb_t;
    sb_t sb_q[$];
    int  n_chk = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] exp);
        sb_q.push_back('{tag: tag, exp: exp});
    endtask

    task automatic sb_pop(input logic [63:0] obs);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_empty: got %h expected an entry", obs);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    // CSR write, committed at the next edge; returns just after that edge
    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_vld_i = 1'b1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = d;
        @(posedge clk_i); #1;
        csr_vld_i = 1'b0; csr_op_i = RD; csr_wdata_i = '0;
    endtask

    // CSR read: drive just after an edge, sample at the following negedge
    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        @(posedge clk_i); #1;
        csr_vld_i = 1'b1; csr_op_i = RD; csr_addr_i = a; csr_wdata_i = '0;
        sb_push(tag, {32'd0, exp});
        @(negedge clk_i);
        sb_pop({32'd0, csr_rdata_o});
        csr_vld_i = 1'b0;
    endtask

    // legality probe: vld is dropped before any edge, so nothing commits
    task automatic ill(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d,
                       input logic exp, input string tag);
        @(posedge clk_i); #1;
        csr_vld_i = 1'b1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = d;
        sb_push(tag, {63'd0, exp});
        @(negedge clk_i);
        sb_pop({63'd0, csr_illegal_o});
        csr_vld_i = 1'b0; csr_op_i = RD; csr_wdata_i = '0;
    endtask

    task automatic peek(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        sb_push(tag, {32'd0, exp});
        sb_pop({32'd0, obs});
    endtask

    initial begin
        rst_n_i = 1'b0; csr_vld_i = 1'b0; csr_op_i = RD; csr_addr_i = '0; csr_wdata_i = '0;
        instret_i = 1'b0; trap_vld_i = 1'b0; mret_i = 1'b0;
        trap_cause_i = '0; trap_pc_i = '0; trap_tval_i = '0;
        irq_ext_i = 1'b0; irq_tmr_i = 1'b0; irq_sw_i = 1'b0;

        // reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        peek("rst_irq_req", {31'd0, irq_req_o}, 32'd0);
        peek("rst_mepc", mepc_o, 32'd0);
        peek("rst_trap_pc", trap_pc_o, 32'd0);
        rst_n_i = 1'b1;

        rd(12'h300, 32'h0000_1800, "mstatus_rst");
        rd(12'h305, 32'h0000_0000, "mtvec_rst");
        @(posedge clk_i); #1;
        csr_vld_i = 1'b1; csr_op_i = RD; csr_addr_i = 12'hB00;
        sb_push("mcycle_rst", cyc & 64'hFFFF_FFFF);
        @(negedge clk_i);
        sb_pop({32'd0, csr_rdata_o});
        csr_vld_i = 1'b0;
        rd(12'hB02, 32'h0, "minstret_rst");
        rd(12'hF14, 32'h0, "mhartid");
        rd(12'h301, 32'h4000_0100, "misa");

        // legality
        ill(RD, 12'h7C0, 32'h0, 1'b1, "ill_unimpl");
        ill(RW, 12'hF14, 32'h5, 1'b1, "ill_wr_hartid");
        ill(RS, 12'hC00, 32'h0, 1'b0, "ill_rs0_cycle");
        ill(RW, 12'hC00, 32'h1, 1'b1, "ill_wr_cycle");
        ill(RC, 12'hF14, 32'h0, 1'b0, "ill_rc0_hartid");
        ill(RS, 12'h300, 32'h0, 1'b0, "ill_rs0_mstatus");

        // RW / RS / RC
        wr(RW, 12'h340, 32'hA5A5_0F0F); rd(12'h340, 32'hA5A5_0F0F, "mscratch_rw");
        wr(RS, 12'h340, 32'h0000_F000); rd(12'h340, 32'hA5A5_FF0F, "mscratch_rs");
        wr(RC, 12'h340, 32'hA5A5_0000); rd(12'h340, 32'h0000_FF0F, "mscratch_rc");

        // write masks
        wr(RW, 12'h300, 32'hFFFF_FFFF); rd(12'h300, 32'h0000_1888, "mstatus_mask");
        wr(RW, 12'h300, 32'h0);         rd(12'h300, 32'h0000_1800, "mstatus_clr");
        wr(RW, 12'h341, 32'h0000_1237); rd(12'h341, 32'h0000_1234, "mepc_mask");
        wr(RW, 12'h305, 32'h8000_0003); rd(12'h305, 32'h8000_0001, "mtvec_mask");
        wr(RW, 12'h344, 32'h0000_0FFF); rd(12'h344, 32'h0, "mip_ro");
        wr(RW, 12'h304, 32'hFFFF_FFFF); rd(12'h304, 32'h0000_0888, "mie_mask");

        // timer interrupt through the synchroniser
        wr(RW, 12'h305, 32'h8000_0001);
        wr(RW, 12'h304, 32'h0000_0080);
        wr(RS, 12'h300, 32'h0000_0008);
        irq_tmr_i = 1'b1;
        @(posedge clk_i); #1;
        peek("irq_after_1edge", {31'd0, irq_req_o}, 32'd0);
        @(posedge clk_i); #1;
        peek("irq_after_2edge", {31'd0, irq_req_o}, 32'd1);
        peek("irq_cause_tmr", irq_cause_o, 32'h8000_0007);

        // trap entry
        trap_vld_i = 1'b1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h0000_1236; trap_tval_i = 32'h55;
        #1;
        peek("trap_pc_vec", trap_pc_o, 32'h8000_001C);
        @(posedge clk_i); #1;
        trap_vld_i = 1'b0; trap_cause_i = 32'h2;
        #1;
        peek("trap_pc_exc", trap_pc_o, 32'h8000_0000);
        peek("trap_mepc", mepc_o, 32'h0000_1234);
        peek("trap_irq_masked", {31'd0, irq_req_o}, 32'd0);
        rd(12'h300, 32'h0000_1880, "trap_mstatus");
        rd(12'h342, 32'h8000_0007, "trap_mcause");
        rd(12'h343, 32'h0000_0055, "trap_mtval");

        // mret
        @(posedge clk_i); #1;
        mret_i = 1'b1;
        @(posedge clk_i); #1;
        mret_i = 1'b0;
        peek("mret_mepc", mepc_o, 32'h0000_1234);
        rd(12'h300, 32'h0000_1888, "mret_mstatus");

        // trap, mret and CSR write together: only the trap lands
        @(posedge clk_i); #1;
        trap_vld_i = 1'b1; trap_cause_i = 32'h2; trap_pc_i = 32'h0000_2000; trap_tval_i = 32'h0;
        mret_i = 1'b1;
        csr_vld_i = 1'b1; csr_op_i = RW; csr_addr_i = 12'h340; csr_wdata_i = 32'hDEAD_BEEF;
        @(posedge clk_i); #1;
        trap_vld_i = 1'b0; mret_i = 1'b0; csr_vld_i = 1'b0; csr_op_i = RD; csr_wdata_i = '0;
        irq_tmr_i = 1'b0;
        peek("combo_mepc", mepc_o, 32'h0000_2000);
        rd(12'h300, 32'h0000_1880, "combo_mstatus");
        rd(12'h340, 32'h0000_FF0F, "combo_mscratch");
        rd(12'h342, 32'h0000_0002, "combo_mcause");

        // counter carry and write-over-increment
        wr(RW, 12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00, 32'h0000_0000, "mcycle_wrap_lo");
        rd(12'hB80, 32'h0000_0001, "mcycleh_carry");
        instret_i = 1'b1;
        wr(RW, 12'hB02, 32'h0000_0100);
        instret_i = 1'b0;
        rd(12'hB02, 32'h0000_0100, "minstret_wr_wins");
        @(posedge clk_i); #1;
        instret_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        instret_i = 1'b0;
        rd(12'hC02, 32'h0000_0103, "instret_count");
        wr(RW, 12'hB82, 32'h0000_0007); rd(12'hC82, 32'h0000_0007, "instreth_wr");

        // ext and sw together, then mask ext
        wr(RS, 12'h300, 32'h0000_0008);
        wr(RW, 12'h304, 32'h0000_0888);
        irq_ext_i = 1'b1; irq_sw_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        peek("irq_cause_ext", irq_cause_o, 32'h8000_000B);
        wr(RC, 12'h304, 32'h0000_0800);
        peek("irq_cause_sw", irq_cause_o, 32'h8000_0003);
        peek("irq_req_sw", {31'd0, irq_req_o}, 32'd1);

        // reset in the middle of a pending write
        wr(RW, 12'h340, 32'h0000_1234);
        @(posedge clk_i); #1;
        csr_vld_i = 1'b1; csr_op_i = RW; csr_addr_i = 12'h340; csr_wdata_i = 32'h9999_9999;
        #2 rst_n_i = 1'b0;
        #1;
        peek("rst_async_irq", {31'd0, irq_req_o}, 32'd0);
        peek("rst_async_mepc", mepc_o, 32'd0);
        @(negedge clk_i);
        csr_vld_i = 1'b0; csr_op_i = RD;
        rst_n_i = 1'b1;
        rd(12'h340, 32'h0, "rst_mscratch");
        rd(12'h300, 32'h0000_1800, "rst_mstatus2");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
